// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multicycle fetch / next-PC controller. Boots the PC, fetches
//               through a req/ack handshake, latches the IR, waits for the
//               datapath, computes the next PC and strobes the PC register.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        ex_done,
  input  logic        zero,
  input  logic [31:0] rs_val,
  output logic [31:0] npc,
  output logic        pcwr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] link_addr,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  err_code
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_JR      = 2'b10;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    WAIT_IM = 3'd2,
    EXEC    = 3'd3,
    UPDATE  = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  logic [31:0] w_npc, w_imem_addr, w_ir, w_link_addr, w_retired;
  logic        w_pcwr, w_imem_req, w_ir_valid, w_halted;
  logic [1:0]  w_err_code;

  logic [31:0] w_pc4, w_br_tgt, w_jmp_tgt, w_target;
  logic        w_is_jr;

  // Branch/jump target selection for the instruction held in the IR.
  always_comb begin
    w_pc4     = pc + 32'd4;
    w_br_tgt  = w_pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    w_jmp_tgt = {w_pc4[31:28], ir[25:0], 2'b00};
    w_is_jr   = (ir[31:26] == OP_SPECIAL) && (ir[5:0] == FN_JR);
    w_target  = w_pc4;
    case (ir[31:26])
      OP_BEQ:     w_target = zero ? w_br_tgt : w_pc4;
      OP_BNE:     w_target = zero ? w_pc4 : w_br_tgt;
      OP_J,
      OP_JAL:     w_target = w_jmp_tgt;
      OP_SPECIAL: w_target = w_is_jr ? rs_val : w_pc4;
      default:    w_target = w_pc4;
    endcase
  end

  // Next-state and next-output logic; every output is registered, so the
  // values computed here appear one cycle later. pcwr is raised on entry to
  // UPDATE so the PC register has loaded the new value by the FETCH cycle.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_npc       = npc;
    w_pcwr      = 1'b0;
    w_imem_req  = imem_req;
    w_imem_addr = imem_addr;
    w_ir        = ir;
    w_ir_valid  = 1'b0;
    w_link_addr = link_addr;
    w_retired   = retired;
    w_halted    = halted;
    w_err_code  = err_code;
    case (r_state)
      BOOT: begin
        // Two-phase: raise the pulse, then move on once it has been seen.
        w_npc = BASE_ADDR;
        if (!pcwr) begin
          w_pcwr = 1'b1;
        end else begin
          w_state = FETCH;
        end
      end
      FETCH: begin
        w_imem_req  = 1'b1;
        w_imem_addr = pc;
        w_link_addr = pc + 32'd4;
        w_cnt       = '0;
        w_state     = WAIT_IM;
      end
      WAIT_IM: begin
        if (imem_ack) begin
          w_ir       = imem_rdata;
          w_ir_valid = 1'b1;
          w_imem_req = 1'b0;
          w_state    = EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_halted   = 1'b1;
          w_err_code = ERR_TIMEOUT;
          w_imem_req = 1'b0;
          w_state    = HALT;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      EXEC: begin
        if (ex_done) begin
          if (w_is_jr && (rs_val[1:0] != 2'b00)) begin
            w_halted   = 1'b1;
            w_err_code = ERR_JR;
            w_state    = HALT;
          end else begin
            w_npc   = w_target;
            w_pcwr  = 1'b1;
            w_state = UPDATE;
          end
        end
      end
      UPDATE: begin
        w_retired = retired + 32'd1;
        w_state   = FETCH;
      end
      HALT: begin
        w_imem_req = 1'b0;
      end
      default: begin
        w_state = BOOT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BOOT;
      r_cnt     <= '0;
      npc       <= BASE_ADDR;
      pcwr      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      link_addr <= '0;
      retired   <= '0;
      halted    <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      npc       <= w_npc;
      pcwr      <= w_pcwr;
      imem_req  <= w_imem_req;
      imem_addr <= w_imem_addr;
      ir        <= w_ir;
      ir_valid  <= w_ir_valid;
      link_addr <= w_link_addr;
      retired   <= w_retired;
      halted    <= w_halted;
      err_code  <= w_err_code;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. The bench
//               drives the pc input itself, standing in for the PC register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ex_done = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] npc;
  logic        pcwr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] link_addr;
  logic [31:0] retired;
  logic        halted;
  logic [1:0]  err_code;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_ret = '0;
  logic [31:0] last_npc = '0;

  pc_sequencer #(.BASE_ADDR(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ex_done(ex_done), .zero(zero),
    .rs_val(rs_val), .npc(npc), .pcwr(pcwr), .imem_req(imem_req),
    .imem_addr(imem_addr), .ir(ir), .ir_valid(ir_valid),
    .link_addr(link_addr), .retired(retired), .halted(halted),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after the UPDATE/BOOT pulse has dropped (state FETCH).
  task automatic do_instr(input string tag, input logic [31:0] pcv,
                          input logic [31:0] instr, input int nwait,
                          input logic z, input logic [31:0] rs,
                          input logic [31:0] exp_npc);
    pc = pcv;
    step();
    chk({tag, ":req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, ":addr"}, imem_addr, pcv);
    chk({tag, ":link"}, link_addr, pcv + 32'd4);
    repeat (nwait) step();
    chk({tag, ":req_held"}, {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack = 1'b0;
    imem_rdata = '0;
    chk({tag, ":ir"}, ir, instr);
    chk({tag, ":ir_valid"}, {31'b0, ir_valid}, 32'd1);
    chk({tag, ":req_drop"}, {31'b0, imem_req}, 32'd0);
    ex_done = 1'b1;
    zero = z;
    rs_val = rs;
    step();
    ex_done = 1'b0;
    chk({tag, ":pcwr"}, {31'b0, pcwr}, 32'd1);
    chk({tag, ":npc"}, npc, exp_npc);
    chk({tag, ":ir_valid_pulse"}, {31'b0, ir_valid}, 32'd0);
    step();
    exp_ret = exp_ret + 32'd1;
    last_npc = exp_npc;
    chk({tag, ":pcwr_pulse"}, {31'b0, pcwr}, 32'd0);
    chk({tag, ":npc_held"}, npc, exp_npc);
    chk({tag, ":retired"}, retired, exp_ret);
  endtask

  initial begin
    // Reset values.
    rst = 1'b1;
    step();
    step();
    chk("rst:npc", npc, 32'h0000_3000);
    chk("rst:pcwr", {31'b0, pcwr}, 32'd0);
    chk("rst:req", {31'b0, imem_req}, 32'd0);
    chk("rst:ir", ir, 32'd0);
    chk("rst:retired", retired, 32'd0);
    chk("rst:halted", {31'b0, halted}, 32'd0);
    chk("rst:err", {30'b0, err_code}, 32'd0);

    // Boot pulse.
    rst = 1'b0;
    step();
    chk("boot:pcwr", {31'b0, pcwr}, 32'd1);
    chk("boot:npc", npc, 32'h0000_3000);
    step();
    chk("boot:pcwr_pulse", {31'b0, pcwr}, 32'd0);

    // Instruction sequence.
    do_instr("add",     32'h0000_3000, 32'h0109_5020, 2, 1'b0, 32'h0, 32'h0000_3004);
    do_instr("beq_z1",  32'h0000_3010, 32'h1000_FFFE, 0, 1'b1, 32'h0, 32'h0000_300C);
    do_instr("beq_z0",  32'h0000_3010, 32'h1000_FFFE, 1, 1'b0, 32'h0, 32'h0000_3014);
    do_instr("bne_z0",  32'h0000_3010, 32'h1400_FFFE, 0, 1'b0, 32'h0, 32'h0000_300C);
    do_instr("bne_z1",  32'h0000_3010, 32'h1400_FFFE, 0, 1'b1, 32'h0, 32'h0000_3014);
    do_instr("j",       32'h0000_3020, 32'h0800_0C40, 0, 1'b0, 32'h0, 32'h0000_3100);
    do_instr("jal",     32'h0000_3020, 32'h0C00_0C40, 0, 1'b0, 32'h0, 32'h0000_3100);
    do_instr("jr",      32'h0000_3020, 32'h03E0_0008, 0, 1'b0, 32'h0000_3200, 32'h0000_3200);
    do_instr("wrap",    32'hFFFF_FFFC, 32'h0109_5020, 0, 1'b0, 32'h0, 32'h0000_0000);
    do_instr("late_ack", 32'h0000_3040, 32'h0109_5020, 15, 1'b0, 32'h0, 32'h0000_3044);

    // Misaligned jr: no PC write, halt with err 10.
    pc = 32'h0000_3030;
    step();
    imem_ack = 1'b1;
    imem_rdata = 32'h03E0_0008;
    step();
    imem_ack = 1'b0;
    ex_done = 1'b1;
    rs_val = 32'h0000_3202;
    step();
    ex_done = 1'b0;
    chk("jr_mis:pcwr", {31'b0, pcwr}, 32'd0);
    chk("jr_mis:halted", {31'b0, halted}, 32'd1);
    chk("jr_mis:err", {30'b0, err_code}, 32'd2);
    repeat (3) step();
    chk("halt:pcwr", {31'b0, pcwr}, 32'd0);
    chk("halt:req", {31'b0, imem_req}, 32'd0);
    chk("halt:npc", npc, last_npc);
    chk("halt:retired", retired, exp_ret);
    chk("halt:sticky", {31'b0, halted}, 32'd1);

    // Recovery through reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rec:halted", {31'b0, halted}, 32'd0);
    chk("rec:err", {30'b0, err_code}, 32'd0);
    chk("rec:retired", retired, 32'd0);
    step();
    chk("rec:pcwr", {31'b0, pcwr}, 32'd1);
    chk("rec:npc", npc, 32'h0000_3000);
    step();

    // Fetch timeout: 15 silent cycles still waiting, the 16th halts.
    pc = 32'h0000_3000;
    step();
    chk("to:req", {31'b0, imem_req}, 32'd1);
    repeat (15) step();
    chk("to:not_yet", {31'b0, halted}, 32'd0);
    chk("to:req_15", {31'b0, imem_req}, 32'd1);
    step();
    chk("to:halted", {31'b0, halted}, 32'd1);
    chk("to:err", {30'b0, err_code}, 32'd1);
    chk("to:req_drop", {31'b0, imem_req}, 32'd0);

    // Reset and run one instruction, then reset mid-fetch with an ack.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    exp_ret = '0;
    do_instr("post_rst", 32'h0000_3000, 32'h0109_5020, 0, 1'b0, 32'h0, 32'h0000_3004);
    pc = 32'h0000_3004;
    step();
    chk("mid:req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    chk("mid:ir", ir, 32'd0);
    chk("mid:ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("mid:retired", retired, 32'd0);
    chk("mid:req", {31'b0, imem_req}, 32'd0);
    step();
    chk("mid:boot_pcwr", {31'b0, pcwr}, 32'd1);
    chk("mid:boot_npc", npc, 32'h0000_3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
